// File: rtl/ac_store_buffer_pkg.sv
// Shared constants, store-entry layout and write-FSM states for the AC store buffer.
package ac_store_buffer_pkg;
  localparam int WORD_SIZE  = 24;
  localparam int ADDR_WIDTH = 16;
  localparam int DEPTH      = 4;
  localparam int PTR_W      = $clog2(DEPTH);
  localparam int CNT_W      = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [WORD_SIZE-1:0]  data;
  } st_entry_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } wr_state_e;
endpackage

// File: rtl/ac_store_buffer_if.sv
// Store-side, load-hazard and memory-write-port signals of the AC store buffer.
interface ac_store_buffer_if;
  import ac_store_buffer_pkg::*;

  logic                  st_en;
  logic [ADDR_WIDTH-1:0] st_addr;
  logic [WORD_SIZE-1:0]  ac_data;
  logic                  st_ready;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic                  ld_hazard;
  logic                  mem_wr_req;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [WORD_SIZE-1:0]  mem_wr_data;
  logic                  mem_wr_ack;
  logic [CNT_W-1:0]      pending;
  logic                  idle;

  modport slave (
    input  st_en, st_addr, ac_data, ld_addr, mem_wr_ack,
    output st_ready, ld_hazard, mem_wr_req, mem_wr_addr, mem_wr_data, pending, idle
  );

  modport master (
    output st_en, st_addr, ac_data, ld_addr, mem_wr_ack,
    input  st_ready, ld_hazard, mem_wr_req, mem_wr_addr, mem_wr_data, pending, idle
  );
endinterface

// File: rtl/ac_store_buffer_store_fifo.sv
// Circular buffer of pending stores; exposes the whole array plus a valid mask
// so the top can compare every live entry against the load address.
module store_fifo
  import ac_store_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  st_entry_t        wr_entry_i,
  output st_entry_t        head_o,
  output st_entry_t        head_next_o,
  output st_entry_t        entries_o [DEPTH],
  output logic [DEPTH-1:0] valid_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  st_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_next_s;
  logic [CNT_W-1:0] count_q;
  logic             push_s;
  logic             pop_s;

  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == CNT_W'(0));
  assign push_s      = push_i && !full_o;
  assign pop_s       = pop_i && !empty_o;
  assign rd_next_s   = rd_ptr_q + PTR_W'(1);
  assign head_o      = mem_q[rd_ptr_q];
  assign head_next_o = mem_q[rd_next_s];
  assign entries_o   = mem_q;
  assign count_o     = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_s)  rd_ptr_q <= rd_next_s;
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_s) mem_q[wr_ptr_q] <= wr_entry_i;
  end

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    valid_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_o[i] = ({1'b0, PTR_W'(i) - rd_ptr_q} < count_q);
    end
  end

endmodule

// File: rtl/ac_store_buffer.sv
// Store buffer between AC and data memory: queues stores, drains them in order
// through a registered write port, and flags loads that hit a pending address.
module ac_store_buffer
  import ac_store_buffer_pkg::*;
(
  input logic              clk,
  input logic              rst,
  ac_store_buffer_if.slave bus
);

  wr_state_e             state_q, state_d;
  logic                  req_q, req_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0]  data_q, data_d;

  st_entry_t             head_s;
  st_entry_t             head_next_s;
  st_entry_t             push_entry_s;
  st_entry_t             entries_s [DEPTH];
  logic [DEPTH-1:0]      valid_s;
  logic [CNT_W-1:0]      count_s;
  logic                  full_s;
  logic                  empty_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  hazard_s;

  assign push_entry_s = {bus.st_addr, bus.ac_data};
  assign push_s       = bus.st_en && !full_s;
  assign pop_s        = (state_q == S_WRITE) && bus.mem_wr_ack;

  store_fifo u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_s),
    .pop_i       (pop_s),
    .wr_entry_i  (push_entry_s),
    .head_o      (head_s),
    .head_next_o (head_next_s),
    .entries_o   (entries_s),
    .valid_o     (valid_s),
    .count_o     (count_s),
    .full_o      (full_s),
    .empty_o     (empty_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // The write port is loaded with the entry that will be head after this edge;
  // with one entry left and a same-cycle push, that is the incoming store.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (!empty_s) begin
          state_d = S_WRITE;
          req_d   = 1'b1;
          addr_d  = head_s.addr;
          data_d  = head_s.data;
        end else begin
          state_d = S_IDLE;
          req_d   = 1'b0;
        end
      end
      S_WRITE: begin
        if (bus.mem_wr_ack) begin
          if (count_s > CNT_W'(1)) begin
            addr_d = head_next_s.addr;
            data_d = head_next_s.data;
          end else if (push_s) begin
            addr_d = push_entry_s.addr;
            data_d = push_entry_s.data;
          end else begin
            state_d = S_IDLE;
            req_d   = 1'b0;
          end
        end else begin
          state_d = S_WRITE;
          req_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    hazard_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hazard_s = hazard_s | (valid_s[i] && (entries_s[i].addr == bus.ld_addr));
    end
  end

  assign bus.st_ready    = !full_s;
  assign bus.ld_hazard   = hazard_s;
  assign bus.mem_wr_req  = req_q;
  assign bus.mem_wr_addr = addr_q;
  assign bus.mem_wr_data = data_q;
  assign bus.pending     = count_s;
  assign bus.idle        = empty_s && (state_q == S_IDLE);

endmodule
